ha_serial_accum: RTL and testbench

//  Bit-serial adder/accumulator stage downstream of the half-adder cell.
//  - Operands arrive LSB-first, one bit pair per cycle.
//  - Each bit pair is combined with a registered carry by two half-adder cells, forming a full adder.
//  - Sum bits are shifted into a WIDTH-bit word, presented with a final carry and a done/ready handshake.
//  - Sits between the ui_in pins (bit stream) and the uo_out pins (result word).

---
 rtl/ha_serial_pkg.sv | 17 +
 rtl/ha_serial_accum_if.sv | 51 +++++
 rtl/ha_cell.sv | 18 +
 rtl/ha_serial_accum.sv | 150 +++++++++++++++
 tb/tb_ha_serial_accum.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/ha_serial_pkg.sv
// ---------------------------------------------------------------------------
// ha_serial_pkg
// Shared definitions for the bit-serial adder/accumulator:
//   DEFAULT_WIDTH : default operand/result width (legal range 2..16)
//   state_t       : controller state encoding (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package ha_serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ha_serial_accum_if.sv
// ---------------------------------------------------------------------------
// ha_serial_accum_if
// Bundles the bit-stream input, the result word and the done/ready handshake
// of ha_serial_accum.
//   start, a_bit, b_bit, bit_valid, out_ready : producer/consumer -> adder
//   sum_word, carry_out, done, busy           : adder -> consumer
// Modports:
//   master : the side that feeds bits and accepts results
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface ha_serial_accum_if
    import ha_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic             a_bit;
    logic             b_bit;
    logic             bit_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_word;
    logic             carry_out;
    logic             done;
    logic             busy;

    modport master (
        output start,
        output a_bit,
        output b_bit,
        output bit_valid,
        output out_ready,
        input  sum_word,
        input  carry_out,
        input  done,
        input  busy
    );

    modport slave (
        input  start,
        input  a_bit,
        input  b_bit,
        input  bit_valid,
        input  out_ready,
        output sum_word,
        output carry_out,
        output done,
        output busy
    );

endinterface

// File: rtl/ha_cell.sv
// ---------------------------------------------------------------------------
// ha_cell
// Purely combinational half adder.
//   i_a, i_b : input bits
//   o_s      : sum   = i_a ^ i_b
//   o_c      : carry = i_a & i_b
// ---------------------------------------------------------------------------
module ha_cell (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;

endmodule

// File: rtl/ha_serial_accum.sv
// ---------------------------------------------------------------------------
// ha_serial_accum
// Bit-serial adder. Operands arrive LSB-first, one bit pair per cycle. Two
// half-adder cells plus a carry flop form a full adder. Sum bits shift into a
// WIDTH-bit word that is presented, with the final carry, under a done/ready
// handshake.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   acc : ha_serial_accum_if.slave
//         start/a_bit/b_bit/bit_valid/out_ready in,
//         sum_word/carry_out/done/busy out
// ---------------------------------------------------------------------------
module ha_serial_accum
    import ha_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    ha_serial_accum_if.slave   acc
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_next;

    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    // Control strobes decoded by the FSM
    logic               w_clear;    // begin a new addition
    logic               w_consume;  // a bit pair is taken this cycle
    logic               w_last;     // the bit pair taken is the final one

    // Full adder built from two half adders
    logic               w_h1_s;
    logic               w_h1_c;
    logic               w_h2_s;
    logic               w_h2_c;
    logic               w_carry_next;
    logic [WIDTH-1:0]   w_shift_next;

    ha_cell u_ha_operands (
        .i_a (acc.a_bit),
        .i_b (acc.b_bit),
        .o_s (w_h1_s),
        .o_c (w_h1_c)
    );

    ha_cell u_ha_carry (
        .i_a (w_h1_s),
        .i_b (r_carry),
        .o_s (w_h2_s),
        .o_c (w_h2_c)
    );

    // Both half-adder carries can never be 1 together, so OR is exact.
    assign w_carry_next = w_h1_c | w_h2_c;

    // New sum bit enters at the MSB; after WIDTH shifts the first bit is bit 0.
    assign w_shift_next = {w_h2_s, r_shift[WIDTH-1:1]};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state and strobes ----------------
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_consume    = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                // Bits presented alongside start are deliberately not consumed.
                if (acc.start) begin
                    w_state_next = RUN;
                    w_clear      = 1'b1;
                end
            end
            RUN: begin
                // start is ignored here; bit_valid=0 simply stalls.
                if (acc.bit_valid) begin
                    w_consume = 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        w_last       = 1'b1;
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (acc.out_ready) begin
                    if (acc.start) begin
                        w_state_next = RUN;
                        w_clear      = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_shift <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            if (w_clear) begin
                r_cnt   <= '0;
                r_carry <= 1'b0;
                r_shift <= '0;
            end else if (w_consume) begin
                r_cnt   <= r_cnt + CNT_ONE;
                r_carry <= w_carry_next;
                r_shift <= w_shift_next;
            end
            // Result registers only change on completion, so they hold
            // through DONE and keep their value after the handshake.
            if (w_last) begin
                r_sum  <= w_shift_next;
                r_cout <= w_carry_next;
            end
        end
    end

    assign acc.sum_word  = r_sum;
    assign acc.carry_out = r_cout;
    assign acc.done      = (r_state == DONE);
    assign acc.busy      = (r_state == RUN);

endmodule

// File: tb/tb_ha_serial_accum.sv
module tb_ha_serial_accum;
    import ha_serial_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ha_serial_accum_if #(.WIDTH(W)) acc();

    ha_serial_accum #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .acc (acc)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition of the two operands.
    task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b};
        chk({tag, "_sum"},   32'(acc.sum_word),  32'(full[W-1:0]));
        chk({tag, "_carry"}, 32'(acc.carry_out), 32'(full[W]));
        chk({tag, "_done"},  32'(acc.done),      32'(1));
    endtask

    // Start from IDLE; the junk bits offered with start must not be consumed.
    task automatic do_start(input string tag);
        acc.start     = 1'b1;
        acc.a_bit     = 1'b1;
        acc.b_bit     = 1'b1;
        acc.bit_valid = 1'b1;
        tick();
        acc.start     = 1'b0;
        acc.bit_valid = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(acc.busy), 32'(1));
    endtask

    // Feed W bit pairs LSB-first; optional stall after bit gap_pos, optional
    // start pulse alongside bit mid_start_idx (must be ignored).
    task automatic send_bits(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int gap_pos, input int gap_len, input int mid_start_idx);
        for (int i = 0; i < W; i++) begin
            acc.a_bit     = a[i];
            acc.b_bit     = b[i];
            acc.bit_valid = 1'b1;
            acc.start     = (i == mid_start_idx);
            tick();
            acc.start     = 1'b0;
            acc.bit_valid = 1'b0;
            if (i == W - 1) begin
                chk({tag, "_done_busy_last"}, 32'({acc.done, acc.busy}), 32'(2'b10));
            end else if (i == gap_pos || i == mid_start_idx) begin
                chk({tag, "_done_busy_mid"}, 32'({acc.done, acc.busy}), 32'(2'b01));
            end
            if (i == gap_pos) begin
                for (int g = 0; g < gap_len; g++) begin
                    acc.bit_valid = 1'b0;
                    acc.a_bit     = 1'($urandom);
                    acc.b_bit     = 1'($urandom);
                    tick();
                    chk({tag, "_stall"}, 32'({acc.done, acc.busy}), 32'(2'b01));
                end
            end
        end
    endtask

    task automatic accept(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b};
        acc.out_ready = 1'b1;
        tick();
        acc.out_ready = 1'b0;
        chk({tag, "_idle_flags"}, 32'({acc.done, acc.busy}), 32'(2'b00));
        chk({tag, "_sum_kept"},   32'(acc.sum_word),         32'(full[W-1:0]));
    endtask

    task automatic full_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int gap_pos, input int gap_len, input int mid_start_idx);
        do_start(tag);
        send_bits(tag, a, b, gap_pos, gap_len, mid_start_idx);
        check_result(tag, a, b);
        $display("op %s: a=0x%02h b=0x%02h -> sum=0x%02h carry=%0d", tag, a, b, acc.sum_word, acc.carry_out);
        accept(tag, a, b);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        acc.start     = 1'b0;
        acc.a_bit     = 1'b0;
        acc.b_bit     = 1'b0;
        acc.bit_valid = 1'b0;
        acc.out_ready = 1'b0;

        // Reset state
        #12;
        chk("reset_outputs", 32'({acc.sum_word, acc.carry_out, acc.done, acc.busy}), 32'(0));
        rst = 1'b0;
        tick();
        chk("idle_after_reset", 32'({acc.done, acc.busy}), 32'(0));

        // Directed operations
        full_op("5A_33", 8'h5A, 8'h33, -1, 0, -1);
        full_op("FF_01", 8'hFF, 8'h01, -1, 0, -1);
        full_op("0F_0F_gap", 8'h0F, 8'h0F, 2, 3, -1);
        full_op("5A_33_midstart", 8'h5A, 8'h33, -1, 0, 3);

        // Reset in the middle of a run
        do_start("rst_mid");
        for (int i = 0; i < 4; i++) begin
            acc.a_bit     = 1'(8'hAA >> i);
            acc.b_bit     = 1'(8'h55 >> i);
            acc.bit_valid = 1'b1;
            tick();
        end
        acc.bit_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_async", 32'({acc.sum_word, acc.carry_out, acc.done, acc.busy}), 32'(0));
        #2 rst = 1'b0;
        tick();
        chk("rst_mid_idle", 32'({acc.sum_word, acc.carry_out, acc.done, acc.busy}), 32'(0));
        full_op("01_01_after_rst", 8'h01, 8'h01, -1, 0, -1);

        // Hold in DONE, then back-to-back start
        do_start("hold");
        send_bits("hold", 8'hC3, 8'h7E, -1, 0, -1);
        check_result("hold", 8'hC3, 8'h7E);
        for (int k = 0; k < 5; k++) begin
            acc.out_ready = 1'b0;
            acc.start     = (k == 2);      // start without out_ready is ignored
            acc.bit_valid = 1'b1;          // bit_valid ignored in DONE
            acc.a_bit     = 1'($urandom);
            acc.b_bit     = 1'($urandom);
            tick();
            acc.start     = 1'b0;
            acc.bit_valid = 1'b0;
            check_result("hold_stable", 8'hC3, 8'h7E);
        end
        acc.out_ready = 1'b1;
        acc.start     = 1'b1;
        acc.bit_valid = 1'b1;
        acc.a_bit     = 1'b1;
        acc.b_bit     = 1'b1;
        tick();
        acc.out_ready = 1'b0;
        acc.start     = 1'b0;
        acc.bit_valid = 1'b0;
        chk("b2b_flags", 32'({acc.done, acc.busy}), 32'(2'b01));
        send_bits("b2b", 8'h80, 8'h80, -1, 0, -1);
        check_result("b2b", 8'h80, 8'h80);
        accept("b2b", 8'h80, 8'h80);

        // Randomised operations
        for (int n = 0; n < 16; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            full_op($sformatf("rnd%0d", n), ra, rb,
                    int'($urandom_range(0, W - 2)), int'($urandom_range(0, 3)),
                    (n % 3 == 0) ? int'($urandom_range(0, W - 2)) : -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
